mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the IF stage (instruction reads) and the MEM

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/arb_streak_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared memory-port widths and arbiter state encoding
// Purpose : types and widths shared by the fetch stage, the data memory stage and
//           the unified-memory port arbiter.
// Contents: MEM_ADDR_W, MEM_DATA_W, arb_state_t.
package mips_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// rtl/arb_streak_counter.sv - saturating count of consecutive data grants
// Purpose : counts data grants made while a fetch is waiting; saturates at MAX_STREAK.
// Ports   : clk, reset (async, active-low)
//           i_inc  - count one more data grant (ignored when saturated)
//           i_clr  - return to zero (wins over i_inc)
//           o_sat  - count has reached MAX_STREAK
module arb_streak_counter #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int CW = $clog2(MAX_STREAK + 1);

  logic [CW-1:0] r_count;

  assign o_sat = (r_count == CW'(MAX_STREAK));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-ported unified memory
// Purpose : grants the memory to the MEM stage (priority) or the IF stage, holds the
//           request until mem_ready, returns read data with a one-cycle valid pulse
//           and stalls the waiting stage. A streak limit keeps fetch from starving.
// Ports   : clk, reset (async, active-low)
//           fetch side : if_req, if_addr, flush -> if_rdata, if_valid, stall_fetch
//           data side  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_valid, stall_mem
//           memory side: mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_fetch,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_kill;
  logic       w_el_data;
  logic       w_el_inst;
  logic       w_grant_data;
  logic       w_grant_inst;
  logic       w_done;
  logic       w_if_deliver;
  logic       w_sat;

  // A requester whose valid is high this cycle is still holding req for the
  // access that just finished, so it must not be granted again.
  assign w_el_data = dm_req & ~dm_valid;
  assign w_el_inst = if_req & ~if_valid & ~flush;

  // A flush seen at any point of the fetch, including its completion cycle,
  // drops the result.
  assign w_if_deliver = (r_state == ARB_INST) & mem_ready & ~r_kill & ~flush;

  assign stall_fetch = if_req & ~if_valid;
  assign stall_mem   = dm_req & ~dm_valid;

  arb_streak_counter #(
    .MAX_STREAK(MAX_STREAK)
  ) u_streak (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_grant_data & if_req),
    .i_clr (w_grant_inst | ~if_req),
    .o_sat (w_sat)
  );

  always_comb begin
    w_next_state = r_state;
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_el_data && !(w_el_inst && w_sat)) begin
          w_grant_data = 1'b1;
          w_next_state = ARB_DATA;
        end else if (w_el_inst) begin
          w_grant_inst = 1'b1;
          w_next_state = ARB_INST;
        end
      end
      ARB_INST, ARB_DATA: begin
        if (mem_ready) begin
          w_done       = 1'b1;
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kill    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      if (w_grant_data) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (w_grant_inst) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        r_kill    <= 1'b0;
      end

      if (r_state == ARB_INST && flush) begin
        r_kill <= 1'b1;
      end

      if (w_done) begin
        mem_req <= 1'b0;
        r_kill  <= 1'b0;
        if (r_state == ARB_INST) begin
          if (w_if_deliver) begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end else begin
          dm_valid <= 1'b1;
          if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        stall_fetch;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .stall_fetch(stall_fetch),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_addr = 32'h1000; dm_we = 0; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %b exp 0", if_valid); end
      n_tests++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dm_valid got %b exp 0", dm_valid); end
    end
    reset = 1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL release_cycle0_mem_req got %b exp 0", mem_req); end
    tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL release_first_mem_req got %b exp 1", mem_req); end
    n_tests++; if (mem_addr !== 32'h1000) begin n_fail++; $display("FAIL release_data_first got %h exp 00001000", mem_addr); end
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h2002000A;
    tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_c1_mem_req got %b exp 1", mem_req); end
    n_tests++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL fetch_c1_addr got %h exp 00000040", mem_addr); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_c1_we got %b exp 0", mem_we); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_c1_valid got %b exp 0", if_valid); end
    tick();
    n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_c2_valid got %b exp 1", if_valid); end
    n_tests++; if (if_rdata !== 32'h2002000A) begin n_fail++; $display("FAIL fetch_c2_rdata got %h exp 2002000a", if_rdata); end
    n_tests++; if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL fetch_c2_stall got %b exp 0", stall_fetch); end
    if_req = 0;
    tick();
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_c3_single_pulse got %b exp 0", if_valid); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_c3_mem_req got %b exp 0", mem_req); end
  endtask

  task automatic test_conflict();
    do_reset();
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    mem_ready = 1; mem_rdata = 32'h11111111;
    tick();
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL conflict_data_first got %h exp 00000100", mem_addr); end
    tick();
    n_tests++; if (dm_valid !== 1'b1) begin n_fail++; $display("FAIL conflict_dm_valid got %b exp 1", dm_valid); end
    n_tests++; if (dm_rdata !== 32'h11111111) begin n_fail++; $display("FAIL conflict_dm_rdata got %h exp 11111111", dm_rdata); end
    dm_req = 0; mem_rdata = 32'h22222222;
    tick();
    n_tests++; if (mem_addr !== 32'h44 || mem_req !== 1'b1) begin n_fail++; $display("FAIL conflict_fetch_second got req=%b addr=%h exp req=1 addr=00000044", mem_req, mem_addr); end
    tick();
    n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL conflict_if_valid got %b exp 1", if_valid); end
    n_tests++; if (if_rdata !== 32'h22222222) begin n_fail++; $display("FAIL conflict_if_rdata got %h exp 22222222", if_rdata); end
    n_tests++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL conflict_no_dm_valid got %b exp 0", dm_valid); end
  endtask

  // Fetch is kept out of the bubble cycles with flush, so the only time both
  // requesters compete is the cycle after each bubble: data must win four times.
  task automatic test_streak();
    int  n_dg;
    logic found;
    logic prev_req;
    do_reset();
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    mem_ready = 1; mem_rdata = 32'h5;
    n_dg = 0; found = 0; prev_req = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      flush = dm_valid;
      if (dm_valid) dm_addr = dm_addr + 32'd4;
      if (mem_req && !prev_req) begin
        if (mem_addr == 32'h80 && !mem_we) found = 1;
        else n_dg++;
      end
      prev_req = mem_req;
      if (found) break;
    end
    flush = 0;
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL streak_fetch_granted got %b exp 1", found); end
    n_tests++; if (n_dg != MAXS) begin n_fail++; $display("FAIL streak_data_grants got %0d exp %0d", n_dg, MAXS); end
  endtask

  task automatic test_wait_states();
    int pulses;
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h10; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    tick();
    dm_req = 0;
    tick();
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    mem_ready = 0; mem_rdata = 32'h12345678;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wait_req_we cyc%0d got req=%b we=%b exp 1 1", i, mem_req, mem_we); end
      n_tests++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL wait_addr cyc%0d got %h exp 00000200", i, mem_addr); end
      n_tests++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wait_wdata cyc%0d got %h exp deadbeef", i, mem_wdata); end
      n_tests++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL wait_early_valid cyc%0d got %b exp 0", i, dm_valid); end
      tick();
    end
    n_tests++; if (dm_valid !== 1'b1) begin n_fail++; $display("FAIL wait_dm_valid got %b exp 1", dm_valid); end
    n_tests++; if (dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait_store_rdata got %h exp cafef00d", dm_rdata); end
    dm_req = 0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dm_valid) pulses++;
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL wait_extra_pulses got %0d exp 0", pulses); end
  endtask

  task automatic test_flush();
    int pulses;
    do_reset();
    if_req = 1; if_addr = 32'h500; mem_ready = 0; mem_rdata = 32'h0BADC0DE;
    tick();
    pulses = 0;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL flush_grant got req=%b addr=%h exp 1 00000500", mem_req, mem_addr); end
    flush = 1; if_addr = 32'h600;
    tick();
    if (if_valid) pulses++;
    flush = 0;
    tick();
    if (if_valid) pulses++;
    mem_ready = 1;
    tick();
    if (if_valid) pulses++;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_mem_done got %b exp 0", mem_req); end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL flush_if_valid_pulses got %0d exp 0", pulses); end
    n_tests++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL flush_rdata_kept got %h exp 00000000", if_rdata); end
    mem_rdata = 32'h600DC0DE;
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin n_fail++; $display("FAIL flush_refetch got req=%b addr=%h exp 1 00000600", mem_req, mem_addr); end
    tick();
    n_tests++; if (if_valid !== 1'b1 || if_rdata !== 32'h600DC0DE) begin n_fail++; $display("FAIL flush_refetch_data got v=%b d=%h exp 1 600dc0de", if_valid, if_rdata); end
    if_req = 0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h700; dm_wdata = 32'h77; mem_ready = 0;
    tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got %b exp 1", mem_req); end
    #2;
    reset = 0;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_async_drop got %b exp 0", mem_req); end
    tick();
    reset = 1; dm_req = 0; mem_ready = 1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dm_valid || if_valid || mem_req) pulses++;
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL rmid_activity_after_release got %0d exp 0", pulses); end
    if_req = 1; if_addr = 32'h900; mem_rdata = 32'h99;
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h900) begin n_fail++; $display("FAIL rmid_idle_grant got req=%b addr=%h exp 1 00000900", mem_req, mem_addr); end
    if_req = 0;
    tick();
  endtask

  // Reference: at most one access owns the memory; a finished access raises its
  // requester's valid for the next cycle only; data beats fetch unless it has
  // already taken MAXS grants in a row while fetch was waiting.
  task automatic test_random();
    int          m_owner;
    int          m_streak;
    int          g;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
    logic        m_we, m_ifv, m_dmv, m_killed, nifv, ndmv, el_d, el_i, pv_if, pv_dm;
    do_reset();
    m_owner = 0; m_streak = 0; m_addr = 0; m_wdata = 0; m_we = 0;
    m_ifr = 0; m_dmr = 0; m_ifv = 0; m_dmv = 0; m_killed = 0; pv_if = 0; pv_dm = 0;
    for (int c = 0; c < 3000; c++) begin
      n_tests++; if (mem_req !== (m_owner != 0)) begin n_fail++; $display("FAIL rnd_mem_req c%0d got %b exp %b", c, mem_req, (m_owner != 0)); end
      if (m_owner != 0) begin
        n_tests++; if (mem_addr !== m_addr || mem_we !== m_we) begin n_fail++; $display("FAIL rnd_mem_cmd c%0d got %h/%b exp %h/%b", c, mem_addr, mem_we, m_addr, m_we); end
        if (m_we) begin
          n_tests++; if (mem_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d got %h exp %h", c, mem_wdata, m_wdata); end
        end
      end
      n_tests++; if (if_valid !== m_ifv) begin n_fail++; $display("FAIL rnd_if_valid c%0d got %b exp %b", c, if_valid, m_ifv); end
      n_tests++; if (dm_valid !== m_dmv) begin n_fail++; $display("FAIL rnd_dm_valid c%0d got %b exp %b", c, dm_valid, m_dmv); end
      n_tests++; if (if_rdata !== m_ifr) begin n_fail++; $display("FAIL rnd_if_rdata c%0d got %h exp %h", c, if_rdata, m_ifr); end
      n_tests++; if (dm_rdata !== m_dmr) begin n_fail++; $display("FAIL rnd_dm_rdata c%0d got %h exp %h", c, dm_rdata, m_dmr); end
      n_tests++; if (if_valid && dm_valid) begin n_fail++; $display("FAIL rnd_both_valid c%0d got 1 exp 0", c); end

      if (!if_req || pv_if) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req || pv_dm) begin
        dm_req   = 1'($urandom_range(0, 1));
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
      end
      flush = ($urandom_range(0, 5) == 0);
      if (flush && if_req && !m_ifv) if_addr = $urandom & 32'hFFFF_FFFC;
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      pv_if = m_ifv;
      pv_dm = m_dmv;
      #1;
      n_tests++; if (stall_fetch !== (if_req && !m_ifv)) begin n_fail++; $display("FAIL rnd_stall_fetch c%0d got %b exp %b", c, stall_fetch, (if_req && !m_ifv)); end
      n_tests++; if (stall_mem !== (dm_req && !m_dmv)) begin n_fail++; $display("FAIL rnd_stall_mem c%0d got %b exp %b", c, stall_mem, (dm_req && !m_dmv)); end

      nifv = 0; ndmv = 0;
      if (m_owner == 0) begin
        el_d = dm_req && !m_dmv;
        el_i = if_req && !m_ifv && !flush;
        g = 0;
        if (el_d && el_i) g = (m_streak == MAXS) ? 1 : 2;
        else if (el_d) g = 2;
        else if (el_i) g = 1;
        if (g == 2) begin m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; end
        else if (g == 1) begin m_addr = if_addr; m_we = 0; m_killed = 0; end
        if (g == 1 || !if_req) m_streak = 0;
        else if (g == 2 && m_streak < MAXS) m_streak++;
        m_owner = g;
      end else begin
        if (m_owner == 1 && flush) m_killed = 1;
        if (mem_ready) begin
          if (m_owner == 1) begin
            if (!m_killed) begin nifv = 1; m_ifr = mem_rdata; end
          end else begin
            ndmv = 1;
            if (!m_we) m_dmr = mem_rdata;
          end
          m_owner = 0;
        end
        if (!if_req) m_streak = 0;
      end
      m_ifv = nifv;
      m_dmv = ndmv;
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_fetch_only();
    test_conflict();
    test_streak();
    test_wait_states();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
